sram_sync_1r1w_be: RTL

//  Parametrised 1-write/1-read synchronous SRAM, successor to the plain 1R1W wrapper. Adds per-lane

---
 rtl/sram_sync_1r1w_be.sv | 113 +++++++++++
 1 files changed

// File: rtl/sram_sync_1r1w_be.sv
// 1-write/1-read synchronous SRAM with per-lane write masks, optional read-during-write
// forwarding, an optional output register and an rvalid strobe.
module sram_sync_1r1w_be #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 256,
    parameter int BYTE_WIDTH  = 8,
    parameter bit TRANSPARENT = 1'b0,
    parameter bit OUT_REG     = 1'b0,
    parameter int W_ADDR      = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [W_ADDR-1:0]             waddr,
    input  logic [WIDTH-1:0]              wdata,
    input  logic [(WIDTH/BYTE_WIDTH)-1:0] wmask,
    input  logic                          wen,
    input  logic [W_ADDR-1:0]             raddr,
    input  logic                          ren,
    output logic [WIDTH-1:0]              rdata,
    output logic                          rvalid
);

    localparam int N_LANES = WIDTH / BYTE_WIDTH;

    logic [WIDTH-1:0]   mem_q [DEPTH];

    logic               rd_fire;
    logic [WIDTH-1:0]   rd_d, rd_q;
    logic               col_d, col_q;
    logic [WIDTH-1:0]   cwdata_d, cwdata_q;
    logic [N_LANES-1:0] cwmask_d, cwmask_q;
    logic               rv1_d, rv1_q;
    logic [WIDTH-1:0]   merged;

    assign rd_fire = rst_n & ren;

    // Array is never reset so it maps onto block RAM; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (rst_n && wen) begin
            for (int i = 0; i < N_LANES; i++) begin
                if (wmask[i]) begin
                    mem_q[waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    always_comb begin
        rd_d     = rd_q;
        col_d    = col_q;
        cwdata_d = cwdata_q;
        cwmask_d = cwmask_q;
        rv1_d    = rd_fire;
        if (rd_fire) begin
            rd_d     = mem_q[raddr];
            col_d    = TRANSPARENT && wen && (waddr == raddr);
            cwdata_d = wdata;
            cwmask_d = wmask;
        end
        if (!rst_n) begin
            col_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        rd_q     <= rd_d;
        col_q    <= col_d;
        cwdata_q <= cwdata_d;
        cwmask_q <= cwmask_d;
        rv1_q    <= rv1_d;
    end

    // A colliding write lands after the array read, so its masked lanes are patched in here.
    always_comb begin
        merged = rd_q;
        for (int i = 0; i < N_LANES; i++) begin
            if (col_q && cwmask_q[i]) begin
                merged[i*BYTE_WIDTH +: BYTE_WIDTH] = cwdata_q[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    generate
        if (OUT_REG) begin : g_out_reg
            logic [WIDTH-1:0] rdo_d, rdo_q;
            logic             rv2_d, rv2_q;

            always_comb begin
                rdo_d = rdo_q;
                rv2_d = rv1_q;
                if (rv1_q) begin
                    rdo_d = merged;
                end
                if (!rst_n) begin
                    rdo_d = '0;
                    rv2_d = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                rdo_q <= rdo_d;
                rv2_q <= rv2_d;
            end

            assign rdata  = rdo_q;
            assign rvalid = rv2_q;
        end else begin : g_no_out_reg
            assign rdata  = merged;
            assign rvalid = rv1_q;
        end
    endgenerate

endmodule
